// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter
//
// Round-robin arbiter sharing one register-map request bus between NUM_REQ
// requesters. One request is latched at a time, issued as a single-cycle strobe
// and held until the register map completes or a timeout forces an error.
// The completion is routed back to the requester that holds the grant.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid        per-requester request (held with payload until req_ready)
//   req_is_wr        per-requester write flag
//   req_addr         packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wr_data      packed write data
//   req_wr_biten     packed per-bit write enables
//   req_ready        one-hot single-cycle completion
//   req_err          error qualifier, valid with req_ready
//   req_rd_data      shared read data, valid with req_ready, held until next capture
//   bus_req          single-cycle strobe to the register map
//   bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten
//                    latched payload of the granted request
//   bus_ready        completion from the register map
//   bus_err          error, qualified by bus_ready
//   bus_rd_data      read data, qualified by bus_ready
//   busy             arbiter is not idle
//   grant_id         index of the current or most recent owner
//   timeout_pulse    one-cycle pulse coincident with a timeout completion

module csr_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned ID_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_is_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_biten,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [DATA_WIDTH-1:0]         req_rd_data,

    output logic                          bus_req,
    output logic                          bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]         bus_addr,
    output logic [DATA_WIDTH-1:0]         bus_wr_data,
    output logic [DATA_WIDTH-1:0]         bus_wr_biten,
    input  logic                          bus_ready,
    input  logic                          bus_err,
    input  logic [DATA_WIDTH-1:0]         bus_rd_data,

    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          timeout_pulse
);

    localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_WIDTH-1:0] LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  wait_cnt_q;
    logic [ID_WIDTH-1:0]   last_grant_q;

    logic                  any_valid;
    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   cand;
    int unsigned           rr_idx;

    // Round-robin search starting one past the previous owner; first hit wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        rr_idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_idx = (32'(last_grant_q) + 32'd1 + k) % NUM_REQ;
            cand   = ID_WIDTH'(rr_idx);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            last_grant_q  <= LAST_INIT;
            grant_id      <= '0;
            bus_req       <= 1'b0;
            bus_req_is_wr <= 1'b0;
            bus_addr      <= '0;
            bus_wr_data   <= '0;
            bus_wr_biten  <= '0;
            req_ready     <= '0;
            req_err       <= '0;
            req_rd_data   <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            // Single-cycle outputs default low and are raised on the transition.
            bus_req       <= 1'b0;
            req_ready     <= '0;
            req_err       <= '0;
            timeout_pulse <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        grant_id      <= winner;
                        bus_req_is_wr <= req_is_wr[winner];
                        bus_addr      <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        bus_wr_data   <= req_wr_data[winner*DATA_WIDTH +: DATA_WIDTH];
                        bus_wr_biten  <= req_wr_biten[winner*DATA_WIDTH +: DATA_WIDTH];
                        bus_req       <= 1'b1;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    wait_cnt_q <= '0;
                    if (bus_ready) begin
                        req_ready[grant_id] <= 1'b1;
                        req_err[grant_id]   <= bus_err;
                        req_rd_data         <= bus_req_is_wr ? '0 : bus_rd_data;
                        state_q             <= StResp;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // A real completion beats a coincident timeout.
                    if (bus_ready) begin
                        req_ready[grant_id] <= 1'b1;
                        req_err[grant_id]   <= bus_err;
                        req_rd_data         <= bus_req_is_wr ? '0 : bus_rd_data;
                        state_q             <= StResp;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        req_ready[grant_id] <= 1'b1;
                        req_err[grant_id]   <= 1'b1;
                        req_rd_data         <= '0;
                        timeout_pulse       <= 1'b1;
                        state_q             <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    last_grant_q <= grant_id;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_bus_arbiter.sv
module tb_csr_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: NUM_REQ=2, TIMEOUT_CYCLES=8
    logic [1:0]  a_req_valid, a_req_is_wr, a_req_ready, a_req_err;
    logic [21:0] a_req_addr;
    logic [63:0] a_req_wr_data, a_req_wr_biten;
    logic [31:0] a_req_rd_data, a_bus_wr_data, a_bus_wr_biten, a_bus_rd_data;
    logic        a_bus_req, a_bus_is_wr, a_bus_ready, a_bus_err, a_busy, a_tp;
    logic [10:0] a_bus_addr;
    logic [0:0]  a_grant_id;

    // Instance B: NUM_REQ=3, TIMEOUT_CYCLES=8
    logic [2:0]  b_req_valid, b_req_is_wr, b_req_ready, b_req_err;
    logic [32:0] b_req_addr;
    logic [95:0] b_req_wr_data, b_req_wr_biten;
    logic [31:0] b_req_rd_data, b_bus_wr_data, b_bus_wr_biten, b_bus_rd_data;
    logic        b_bus_req, b_bus_is_wr, b_bus_ready, b_bus_err, b_busy, b_tp;
    logic [10:0] b_bus_addr;
    logic [1:0]  b_grant_id;

    csr_bus_arbiter #(
        .NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(11), .TIMEOUT_CYCLES(8)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_is_wr(a_req_is_wr), .req_addr(a_req_addr),
        .req_wr_data(a_req_wr_data), .req_wr_biten(a_req_wr_biten),
        .req_ready(a_req_ready), .req_err(a_req_err), .req_rd_data(a_req_rd_data),
        .bus_req(a_bus_req), .bus_req_is_wr(a_bus_is_wr), .bus_addr(a_bus_addr),
        .bus_wr_data(a_bus_wr_data), .bus_wr_biten(a_bus_wr_biten),
        .bus_ready(a_bus_ready), .bus_err(a_bus_err), .bus_rd_data(a_bus_rd_data),
        .busy(a_busy), .grant_id(a_grant_id), .timeout_pulse(a_tp)
    );

    csr_bus_arbiter #(
        .NUM_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(11), .TIMEOUT_CYCLES(8)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_is_wr(b_req_is_wr), .req_addr(b_req_addr),
        .req_wr_data(b_req_wr_data), .req_wr_biten(b_req_wr_biten),
        .req_ready(b_req_ready), .req_err(b_req_err), .req_rd_data(b_req_rd_data),
        .bus_req(b_bus_req), .bus_req_is_wr(b_bus_is_wr), .bus_addr(b_bus_addr),
        .bus_wr_data(b_bus_wr_data), .bus_wr_biten(b_bus_wr_biten),
        .bus_ready(b_bus_ready), .bus_err(b_bus_err), .bus_rd_data(b_bus_rd_data),
        .busy(b_busy), .grant_id(b_grant_id), .timeout_pulse(b_tp)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance A. lat = cycles from strobe to bus_ready, -1 = never.
    typedef struct {
        int          id;
        logic        is_wr;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] biten;
        int          lat;
        logic        berr;
        logic [31:0] brd;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        exp_tp;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input logic [31:0] prev_rd);
        int s, rc, nreq;
        logic [1:0]  rdy, err;
        logic [31:0] rd, cap_wd, cap_be;
        logic [10:0] cap_addr;
        logic        tp, cap_wr;
        logic [0:0]  gid;
        s = -1; rc = -1; nreq = 0;
        rdy = '0; err = '0; rd = '0; tp = 1'b0; gid = '0;
        cap_addr = '0; cap_wd = '0; cap_be = '0; cap_wr = 1'b0;
        step();
        chk("idle_ready", a_req_ready, 0);
        chk("rd_data_held", a_req_rd_data, prev_rd);
        // Cycle 0: only requester v.id valid; other slices carry distinct junk.
        a_req_addr       = 22'h3F_FFFF;
        a_req_wr_data    = {2{32'h5A5A_5A5A}};
        a_req_wr_biten   = {2{32'h0000_FFFF}};
        a_req_is_wr      = ~{2{v.is_wr}};
        a_req_valid      = '0;
        a_req_valid[v.id]              = 1'b1;
        a_req_is_wr[v.id]              = v.is_wr;
        a_req_addr[v.id*11 +: 11]      = v.addr;
        a_req_wr_data[v.id*32 +: 32]   = v.wdata;
        a_req_wr_biten[v.id*32 +: 32]  = v.biten;
        a_bus_err     = v.berr;
        a_bus_rd_data = v.brd;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (a_req_ready != 0) begin
                rc = c; rdy = a_req_ready; err = a_req_err; rd = a_req_rd_data;
                tp = a_tp; gid = a_grant_id;
                a_req_valid = '0;
                a_bus_ready = 1'b0;
                break;
            end
            if (a_bus_req) begin
                nreq++;
                if (s < 0) begin
                    s = c; cap_addr = a_bus_addr; cap_wd = a_bus_wr_data;
                    cap_be = a_bus_wr_biten; cap_wr = a_bus_is_wr;
                end
            end
            a_bus_ready = (s >= 0) && (v.lat >= 0) && (c == s + v.lat);
        end
        chk("strobe_cycle", s, 1);
        chk("strobe_count", nreq, 1);
        chk("ready_cycle", rc, v.exp_cyc);
        chk("ready_onehot", rdy, 2'b01 << v.id);
        chk("req_err", err, {1'b0, v.exp_err} << v.id);
        chk("req_rd_data", rd, v.exp_rd);
        chk("timeout_pulse", tp, v.exp_tp);
        chk("grant_id", gid, v.id);
        chk("bus_addr", cap_addr, v.addr);
        chk("bus_wr_data", cap_wd, v.wdata);
        chk("bus_wr_biten", cap_be, v.biten);
        chk("bus_is_wr", cap_wr, v.is_wr);
    endtask

    initial begin
        int n_iss, n_rdy, n_b;
        logic any_rdy, any_busy;
        int   b_order[3];
        logic [31:0] prev_rd;

        vecs[0] = '{0, 1'b0, 11'h010, 32'h0, 32'h0, 1, 1'b0, 32'hDEAD_BEEF,
                    3, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1, 1'b1, 11'h123, 32'hA5A5_0F0F, 32'hFFFF_0000, 0, 1'b1, 32'h0000_1234,
                    2, 1'b1, 32'h0, 1'b0};
        vecs[2] = '{0, 1'b0, 11'h7FF, 32'h0, 32'h0, -1, 1'b0, 32'h0000_0055,
                    10, 1'b1, 32'h0, 1'b1};
        vecs[3] = '{1, 1'b0, 11'h400, 32'h0, 32'h0, 8, 1'b0, 32'hCAFE_F00D,
                    10, 1'b0, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{0, 1'b0, 11'h0F0, 32'h0, 32'h0, 3, 1'b1, 32'h0000_0BAD,
                    5, 1'b1, 32'h0000_0BAD, 1'b0};

        rst = 1'b1;
        a_req_valid = '0; a_req_is_wr = '0; a_req_addr = '0;
        a_req_wr_data = '0; a_req_wr_biten = '0;
        a_bus_ready = 1'b0; a_bus_err = 1'b0; a_bus_rd_data = '0;
        b_req_valid = '0; b_req_is_wr = '0; b_req_addr = {11'h003, 11'h002, 11'h001};
        b_req_wr_data = '0; b_req_wr_biten = '0;
        b_bus_ready = 1'b0; b_bus_err = 1'b0; b_bus_rd_data = '0;
        repeat (3) step();

        chk("rst_busy", a_busy, 0);
        chk("rst_grant_id", a_grant_id, 0);
        chk("rst_bus_req", a_bus_req, 0);
        chk("rst_bus_addr", a_bus_addr, 0);
        chk("rst_req_ready", a_req_ready, 0);
        chk("rst_req_err", a_req_err, 0);
        chk("rst_rd_data", a_req_rd_data, 0);
        chk("rst_timeout_pulse", a_tp, 0);
        chk("rst_b_grant_id", b_grant_id, 0);
        rst = 1'b0;

        prev_rd = '0;
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], prev_rd);
            prev_rd = vecs[i].exp_rd;
        end

        // Reset during WAIT abandons the transaction; a late bus_ready is ignored.
        step();
        a_req_valid = 2'b10; a_req_is_wr = 2'b00; a_req_addr = {11'h155, 11'h0AA};
        a_bus_rd_data = 32'h1111_1111; a_bus_err = 1'b0;
        repeat (3) step();
        chk("pre_rst_grant", a_grant_id, 1);
        chk("pre_rst_busy", a_busy, 1);
        rst = 1'b1; a_req_valid = '0;
        step();
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_grant", a_grant_id, 0);
        chk("mid_rst_bus_addr", a_bus_addr, 0);
        chk("mid_rst_rd_data", a_req_rd_data, 0);
        chk("mid_rst_ready", a_req_ready, 0);
        rst = 1'b0;
        step();
        a_bus_ready = 1'b1;
        step();
        a_bus_ready = 1'b0;
        any_rdy = 1'b0; any_busy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            any_rdy  = any_rdy | (|a_req_ready);
            any_busy = any_busy | a_busy;
            step();
        end
        chk("late_ready_ignored", any_rdy, 0);
        chk("late_ready_busy", any_busy, 0);

        // Both requesters valid, zero-latency map: 0,1,0,1 every 3 cycles.
        a_req_valid = 2'b11;
        n_iss = 0; n_rdy = 0;
        for (int c = 1; c <= 11; c++) begin
            step();
            a_bus_ready = a_bus_req;
            if (a_bus_req) begin
                chk("alt_bus_addr", a_bus_addr, (n_iss % 2 == 0) ? 11'h0AA : 11'h155);
                n_iss++;
            end
            if (a_req_ready != 0) begin
                chk("alt_ready_id", a_req_ready, (n_rdy % 2 == 0) ? 2'b01 : 2'b10);
                chk("alt_ready_cycle", c, 2 + 3 * n_rdy);
                n_rdy++;
            end
        end
        a_req_valid = '0; a_bus_ready = 1'b0;
        chk("alt_ready_count", n_rdy, 4);

        // NUM_REQ=3: requester 2 alone, then 0 and 2 -> order 2,0,2.
        b_order[0] = 2; b_order[1] = 0; b_order[2] = 2;
        step();
        b_req_valid = 3'b100;
        n_iss = 0; n_b = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            b_bus_ready = b_bus_req;
            if (b_bus_req && n_iss < 3) begin
                chk("b_bus_addr", b_bus_addr, 11'(b_order[n_iss] + 1));
                n_iss++;
            end
            if (b_req_ready != 0) begin
                chk("b_ready_id", b_req_ready, 3'b001 << b_order[n_b]);
                chk("b_grant_id", b_grant_id, b_order[n_b]);
                n_b++;
                if (n_b == 1) b_req_valid = 3'b101;
                if (n_b == 3) begin
                    b_req_valid = '0;
                    b_bus_ready = 1'b0;
                    break;
                end
            end
        end
        chk("b_ready_count", n_b, 3);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
